// File: rtl/sad_array_builder.sv
// Accumulates one SAD per candidate over a cur/ref pixel stream and packs 16 SADs for the MIN_16 min-search.
// Optional feature: define SAD_SATURATE_EN to clamp each SAD instead of letting it wrap.
module sad_array_builder #(
  parameter int ELEMENT_BIT_DEPTH    = 14,
  parameter int PIXEL_BIT_DEPTH      = 8,
  parameter int PIXELS_PER_CANDIDATE = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            restart,
  input  logic                            pix_valid,
  output logic                            pix_ready,
  input  logic [PIXEL_BIT_DEPTH-1:0]      cur_pix,
  input  logic [PIXEL_BIT_DEPTH-1:0]      ref_pix,
  output logic [ELEMENT_BIT_DEPTH*16-1:0] min_array,
  output logic                            array_valid,
  input  logic                            array_ready
);

  localparam int EBD = ELEMENT_BIT_DEPTH;
  localparam int PCW = (PIXELS_PER_CANDIDATE > 1) ? $clog2(PIXELS_PER_CANDIDATE) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state, next_state;
  logic [EBD-1:0]       acc;
  logic [PCW-1:0]       pix_cnt;
  logic [3:0]           cand_cnt;
  logic                 accept;
  logic                 last_pix;
  logic [PIXEL_BIT_DEPTH-1:0] diff;
  logic [EBD-1:0]       sum;

  assign accept   = pix_valid & pix_ready;
  assign last_pix = (pix_cnt == PCW'(PIXELS_PER_CANDIDATE - 1));

  // Compare first so the absolute difference never needs a sign bit.
  always_comb begin
    if (cur_pix >= ref_pix) diff = cur_pix - ref_pix;
    else                    diff = ref_pix - cur_pix;
  end

`ifdef SAD_SATURATE_EN
  logic [EBD:0] sum_full;

  always_comb begin
    sum_full = {1'b0, acc} + (EBD+1)'(diff);
    sum      = sum_full[EBD] ? {EBD{1'b1}} : sum_full[EBD-1:0];
  end
`else
  always_comb begin
    sum = acc + EBD'(diff);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ACCUM: if (!restart && accept && last_pix && cand_cnt == 4'd15) next_state = HOLD;
      HOLD:  if (restart || array_ready) next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  always_comb begin
    pix_ready   = (state == ACCUM) && !rst;
    array_valid = (state == HOLD);
  end

  // Slot k is written by the k-th candidate; cand_cnt wraps to 0 on the 16th.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      pix_cnt   <= '0;
      cand_cnt  <= '0;
      min_array <= '0;
    end else if (restart) begin
      acc      <= '0;
      pix_cnt  <= '0;
      cand_cnt <= '0;
      if (state == HOLD) begin
        min_array <= '0;
      end else begin
        for (int k = 0; k < 16; k++) begin
          if (k < int'(cand_cnt)) min_array[k*EBD +: EBD] <= '0;
        end
      end
    end else if (accept) begin
      if (last_pix) begin
        min_array[int'(cand_cnt)*EBD +: EBD] <= sum;
        acc      <= '0;
        pix_cnt  <= '0;
        cand_cnt <= cand_cnt + 4'd1;
      end else begin
        acc     <= sum;
        pix_cnt <= pix_cnt + PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sad_array_builder.sv
// Directed self-checking bench for sad_array_builder: reset, full arrays, back-pressure, restart, gaps, overflow.
module tb_sad_array_builder;

  localparam int EBD = 14;

  logic           clk = 1'b0;
  logic           rst, restart, pix_valid, array_ready;
  logic [7:0]     cur_pix, ref_pix;
  logic           pix_ready, array_valid;
  logic [EBD*16-1:0] min_array;

  logic           restart2, pix_valid2, array_ready2;
  logic [7:0]     cur_pix2, ref_pix2;
  logic           pix_ready2, array_valid2;
  logic [EBD*16-1:0] min_array2;

  logic [EBD*16-1:0] exp_array;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sad_array_builder dut (
    .clk(clk), .rst(rst), .restart(restart), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .min_array(min_array), .array_valid(array_valid),
    .array_ready(array_ready)
  );

  sad_array_builder #(.PIXELS_PER_CANDIDATE(128)) dut128 (
    .clk(clk), .rst(rst), .restart(restart2), .pix_valid(pix_valid2), .pix_ready(pix_ready2),
    .cur_pix(cur_pix2), .ref_pix(ref_pix2), .min_array(min_array2), .array_valid(array_valid2),
    .array_ready(array_ready2)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    else
      passes++;
  endtask

  task automatic checkArray(input string tag);
    for (int k = 0; k < 16; k++)
      checkOutput($sformatf("%s_slot%0d", tag, k), 256'(min_array[k*EBD +: EBD]),
                  256'(exp_array[k*EBD +: EBD]));
  endtask

  // Streams the first n_pairs of the reference pattern: cur=10, ref=k+3 for candidate k.
  task automatic applyStimulus(input int n_pairs, input bit gaps);
    int k;
    int idle;
    for (int i = 0; i < n_pairs; i++) begin
      k = i / 64;
      if (gaps) begin
        idle = $urandom_range(0, 2);
        pix_valid = 1'b0;
        cur_pix   = 8'd99;
        ref_pix   = 8'd0;
        repeat (idle) begin @(posedge clk); #1; end
      end
      pix_valid = 1'b1;
      cur_pix   = 8'd10;
      ref_pix   = 8'(k + 3);
      if (i == 1023) checkOutput("valid_before_last", 256'(array_valid), 256'(0));
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    if (n_pairs == 1024) checkOutput("valid_after_last", 256'(array_valid), 256'(1));
  endtask

  task automatic pulseReady();
    array_ready = 1'b1;
    @(posedge clk); #1;
    array_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; pix_valid = 1'b0; array_ready = 1'b0;
    cur_pix = '0; ref_pix = '0;
    restart2 = 1'b0; pix_valid2 = 1'b0; array_ready2 = 1'b0;
    cur_pix2 = '0; ref_pix2 = '0;
    for (int k = 0; k < 16; k++)
      exp_array[k*EBD +: EBD] = EBD'(64 * ((k > 7) ? (k - 7) : (7 - k)));

    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pix_ready", 256'(pix_ready), 256'(0));
    checkOutput("rst_array_valid", 256'(array_valid), 256'(0));
    checkOutput("rst_min_array", 256'(min_array), 256'(0));
    checkOutput("rst_min_array128", 256'(min_array2), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_pix_ready", 256'(pix_ready), 256'(1));

    $display("[TB] full array");
    applyStimulus(1024, 1'b0);
    checkArray("s2");

    $display("[TB] back-pressure");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_pix_ready%0d", c), 256'(pix_ready), 256'(0));
      checkOutput($sformatf("hold_valid%0d", c), 256'(array_valid), 256'(1));
      checkOutput($sformatf("hold_array%0d", c), 256'(min_array), 256'(exp_array));
    end
    pulseReady();
    checkOutput("handoff_valid", 256'(array_valid), 256'(0));
    checkOutput("handoff_pix_ready", 256'(pix_ready), 256'(1));

    $display("[TB] restart mid-array");
    applyStimulus(5 * 64 + 30, 1'b0);
    restart   = 1'b1;
    pix_valid = 1'b1;
    cur_pix   = 8'd200;
    ref_pix   = 8'd0;
    @(posedge clk); #1;
    restart   = 1'b0;
    pix_valid = 1'b0;
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("restart_slot%0d", k), 256'(min_array[k*EBD +: EBD]), 256'(0));
    checkOutput("restart_valid", 256'(array_valid), 256'(0));
    applyStimulus(1024, 1'b0);
    checkArray("s5");
    pulseReady();

    $display("[TB] gapped stream");
    applyStimulus(1024, 1'b1);
    checkArray("s6");

    $display("[TB] restart while holding");
    restart     = 1'b1;
    array_ready = 1'b1;
    @(posedge clk); #1;
    restart     = 1'b0;
    array_ready = 1'b0;
    checkOutput("hold_restart_valid", 256'(array_valid), 256'(0));
    checkOutput("hold_restart_array", 256'(min_array), 256'(0));
    checkOutput("hold_restart_pix_ready", 256'(pix_ready), 256'(1));

    $display("[TB] overflow with 128 pixels per candidate");
    for (int i = 0; i < 128; i++) begin
      pix_valid2 = 1'b1;
      cur_pix2   = 8'd255;
      ref_pix2   = 8'd0;
      @(posedge clk); #1;
    end
    pix_valid2 = 1'b0;
`ifdef SAD_SATURATE_EN
    checkOutput("ovf_slot0", 256'(min_array2[EBD-1:0]), 256'(16383));
`else
    checkOutput("ovf_slot0", 256'(min_array2[EBD-1:0]), 256'(16256));
`endif
    checkOutput("ovf_slot1", 256'(min_array2[2*EBD-1:EBD]), 256'(0));
    checkOutput("ovf_valid", 256'(array_valid2), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
